pulse_shaper: RTL

PULSE_SHAPER -- requirements
Module: pulse_shaper

---
 rtl/pulse_shaper.sv | 114 +++++++++++
 1 files changed

// File: rtl/pulse_shaper.sv
// Retriggerable pulse shaper: each trig rising edge requests one fixed-width
// pulse; requests arriving while busy are queued in a saturating counter.
module pulse_shaper #(
    parameter int HIGH_LEN = 8,
    parameter int LOW_LEN  = 8,
    parameter int PEND_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trig,
    input  logic              enable,
    input  logic              clr_ovf,
    output logic              out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              ovf
);

    localparam int MAX_LEN = (HIGH_LEN > LOW_LEN) ? HIGH_LEN : LOW_LEN;
    localparam int CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [CNT_W-1:0]  HIGH_LAST = CNT_W'(HIGH_LEN - 1);
    localparam logic [CNT_W-1:0]  LOW_LAST  = CNT_W'(LOW_LEN - 1);
    localparam logic [PEND_W-1:0] PEND_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        GAP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             trig_d;
    logic             armed;
    logic             req;
    logic             eligible;
    logic             start;
    logic             drop;

    // armed masks the first edge after reset so a trig already high is not a request
    always_comb begin
        req      = trig & ~trig_d & armed;
        eligible = (state == IDLE) || ((state == GAP) && (cnt == LOW_LAST));
        start    = eligible & enable & (req | (pending != '0));
        drop     = req & ~start & (pending == PEND_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            trig_d  <= 1'b0;
            armed   <= 1'b0;
            out     <= 1'b0;
            busy    <= 1'b0;
            pending <= '0;
            ovf     <= 1'b0;
        end else begin
            trig_d <= trig;
            armed  <= 1'b1;

            // a request in the start cycle is consumed by that start
            if (start && !req)
                pending <= pending - 1'b1;
            else if (!start && req && (pending != PEND_MAX))
                pending <= pending + 1'b1;

            if (drop)
                ovf <= 1'b1;
            else if (clr_ovf)
                ovf <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        state <= HIGH;
                        cnt   <= '0;
                        out   <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                HIGH: begin
                    if (cnt == HIGH_LAST) begin
                        state <= GAP;
                        cnt   <= '0;
                        out   <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (start) begin
                        state <= HIGH;
                        cnt   <= '0;
                        out   <= 1'b1;
                    end else if (cnt == LOW_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    out   <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
